// File: rtl/music_pkg.sv
// Shared constants for the beat sequencer: scene codes, track IDs,
// FSM state codes and the default song lengths.
package music_pkg;

  localparam logic [1:0] SCENE_START = 2'b00;
  localparam logic [1:0] SCENE_GAME  = 2'b01;
  localparam logic [1:0] SCENE_WIN   = 2'b10;
  localparam logic [1:0] SCENE_LOSE  = 2'b11;

  localparam int TRK_BAD_APPLE = 0;
  localparam int TRK_UN_OWEN   = 1;
  localparam int TRK_BOSS      = 2;
  localparam int TRK_WIN       = 3;
  localparam int TRK_LOSE      = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int LEN_BAD_APPLE = 768;
  localparam int LEN_UN_OWEN   = 352;
  localparam int LEN_BOSS      = 133;
  localparam int LEN_WIN       = 297;
  localparam int LEN_LOSE      = 136;

endpackage

// File: rtl/music_tempo_div.sv
// Beat prescaler: passes every (div+1)-th enabled strobe as a tick.
// Counter freezes while hold is high and restarts from zero on clr.
module music_tempo_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             hold,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic             step;

  assign step = en & ~hold;
  assign tick = step & (count == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else if (step) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/music_beat_sequencer.sv
// Multi-track beat-index sequencer with loop/one-shot tracks.
// Optional beat prescaler enabled by defining SEQ_PRESCALE_EN.
module music_beat_sequencer
  import music_pkg::*;
#(
  parameter int NUM_TRACKS = 8,
  parameter int BEAT_W     = 10,
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         beat_en,
  input  logic [SEL_W-1:0]             track_sel,
  input  logic [NUM_TRACKS*BEAT_W-1:0] track_len,
  input  logic [NUM_TRACKS-1:0]        loop_mask,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         pause,
  input  logic [DIV_W-1:0]             tempo_div,
  output logic [BEAT_W-1:0]            ibeat,
  output logic [SEL_W-1:0]             track_cur,
  output logic                         playing,
  output logic                         wrap,
  output logic                         done
);

  logic [1:0]        state;
  logic [BEAT_W-1:0] len;
  logic              loop;
  logic              chg;
  logic              adv;
  logic              last;
  logic              tick;

  assign len  = track_len[track_cur*BEAT_W +: BEAT_W];
  assign loop = loop_mask[track_cur];
  assign chg  = (state != ST_IDLE) && (track_sel != track_cur);
  assign adv  = (state == ST_PLAY) && !stop && !start && !chg && !pause;
  // widened compare so len==0 and a shrunken len both count as end-of-track
  assign last = ({1'b0, ibeat} + 1'b1) >= {1'b0, len};
  assign playing = (state == ST_PLAY);

`ifdef SEQ_PRESCALE_EN
  music_tempo_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (beat_en),
    .hold  (!adv),
    .clr   (start | stop | chg),
    .div   (tempo_div),
    .tick  (tick)
  );
`else
  logic unused_div;
  assign unused_div = ^tempo_div;
  assign tick = beat_en & adv;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ibeat     <= '0;
      track_cur <= '0;
      wrap      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        ibeat <= '0;
      end else if (start) begin
        state     <= ST_PLAY;
        track_cur <= track_sel;
        ibeat     <= '0;
      end else if (chg) begin
        track_cur <= track_sel;
        ibeat     <= '0;
        state     <= (state == ST_PAUSE) ? ST_PAUSE : ST_PLAY;
      end else if (state == ST_PLAY && pause) begin
        state <= ST_PAUSE;
      end else if (state == ST_PAUSE && !pause) begin
        state <= ST_PLAY;
      end else if (tick && adv) begin
        if (!last) begin
          ibeat <= ibeat + 1'b1;
        end else if (loop) begin
          ibeat <= '0;
          wrap  <= 1'b1;
        end else begin
          ibeat <= (len == '0) ? '0 : len - 1'b1;
          state <= ST_HOLD;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
